// File: rtl/srm_pkg.sv
// Shared constants and next-PC source encoding for the Simple RISC Machine.
package srm_pkg;

    localparam int              ADDR_W       = 9;
    localparam logic [ADDR_W-1:0] PC_RESET_VEC = 9'd0;
    localparam int              LINK_PAD_W   = 7;

    typedef enum logic [1:0] {
        NPC_ZERO,
        NPC_REG,
        NPC_REL,
        NPC_SEQ
    } npc_src_e;

    // tsel beats execb so an illegal tsel+execb combination still lands on the register target.
    function automatic npc_src_e npc_select(input logic reset_pc, input logic tsel, input logic execb);
        if (reset_pc)   return NPC_ZERO;
        else if (tsel)  return NPC_REG;
        else if (execb) return NPC_REL;
        return NPC_SEQ;
    endfunction

endpackage

// File: rtl/pc_addr_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and a freeze input.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          hold,
    output logic [CW-1:0] count
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count;
        if (reset)
            w_count_d = '0;
        else if (inc && !hold && (r_count != {CW{1'b1}}))
            w_count_d = r_count + CW'(1);
    end

    vDFF #(.N(CW)) u_count_reg (
        .clk (clk),
        .in  (w_count_d),
        .out (r_count)
    );

    assign count = r_count;

endmodule

// File: rtl/vDFF.sv
// Plain N-bit D flip-flop; enables and reset are muxed in front by the caller.
module vDFF #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    // NOTE: sequential state uses non-blocking assignment so all registers sample together.
    always_ff @(posedge clk) begin
        out <= in;
    end

endmodule

// File: rtl/pc_addr_unit.sv
// PC / data-address unit: next-PC priority mux, DA register and RAM address mux.
// Optional performance counters are built only when PC_PERF_CNT_EN is defined.
module pc_addr_unit
    import srm_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reset_pc,
    input  logic          rsel,
    input  logic          execb,
    input  logic          tsel,
    input  logic          addr_sel,
    input  logic          load_addr,
    input  logic          load_ir,
    input  logic          w8,
    input  logic [15:0]   sximm8,
    input  logic [15:0]   reg_target,
    input  logic [15:0]   dp_out,
    output logic [AW-1:0] pc,
    output logic [15:0]   pc_next,
    output logic [AW-1:0] mem_addr,
    output logic [CW-1:0] instr_count,
    output logic [CW-1:0] branch_count
);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_da;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_npc;
    logic [AW-1:0] w_pc_d;
    logic [AW-1:0] w_da_d;
    logic          w_load_pc;
    npc_src_e      w_npc_src;

    assign w_load_pc = reset_pc | rsel | execb | tsel;
    assign w_npc_src = npc_select(reset_pc, tsel, execb);
    assign w_pc_inc  = r_pc + AW'(1);

    // NOTE: every always_comb output is assigned a default first so no path infers a latch.
    always_comb begin
        w_npc = w_pc_inc;
        unique case (w_npc_src)
            NPC_ZERO: w_npc = AW'(PC_RESET_VEC);
            NPC_REG:  w_npc = reg_target[AW-1:0];
            NPC_REL:  w_npc = w_pc_inc + sximm8[AW-1:0];
            NPC_SEQ:  w_npc = w_pc_inc;
        endcase
    end

    assign w_pc_d = reset ? AW'(PC_RESET_VEC) : (w_load_pc ? w_npc : r_pc);
    assign w_da_d = reset ? '0 : (load_addr ? dp_out[AW-1:0] : r_da);

    vDFF #(.N(AW)) u_pc_reg (
        .clk (clk),
        .in  (w_pc_d),
        .out (r_pc)
    );

    vDFF #(.N(AW)) u_da_reg (
        .clk (clk),
        .in  (w_da_d),
        .out (r_da)
    );

    assign pc       = r_pc;
    assign mem_addr = addr_sel ? r_pc : r_da;
    // Link value comes from the pre-update PC, so BL links to the instruction after itself.
    assign pc_next  = {{(16-AW){1'b0}}, w_pc_inc};

    logic w_unused_hi;
    assign w_unused_hi = &{1'b0, sximm8[15:AW], reg_target[15:AW], dp_out[15:AW]};

`ifdef PC_PERF_CNT_EN
    sat_counter #(.CW(CW)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (load_ir),
        .hold  (w8),
        .count (instr_count)
    );

    sat_counter #(.CW(CW)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (execb | tsel),
        .hold  (w8),
        .count (branch_count)
    );
`else
    assign instr_count  = '0;
    assign branch_count = '0;

    logic w_unused_perf;
    assign w_unused_perf = &{1'b0, load_ir, w8};
`endif

endmodule

// File: tb/tb_pc_addr_unit.sv
// Scoreboard bench for pc_addr_unit; counter expectations follow PC_PERF_CNT_EN.
module tb_pc_addr_unit;

    localparam int AW = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, reset_pc, rsel, execb, tsel, addr_sel, load_addr, load_ir, w8;
    logic [15:0]   sximm8, reg_target, dp_out;
    logic [AW-1:0] pc, mem_addr;
    logic [15:0]   pc_next;
    logic [CW-1:0] instr_count, branch_count;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] ma;
        logic [15:0]   pn;
        logic [CW-1:0] ic;
        logic [CW-1:0] bc;
    } obs_t;

    obs_t          sb[$];
    logic [AW-1:0] m_pc, m_da;
    logic [CW-1:0] m_ic, m_bc;
    int            checks = 0;
    int            errors = 0;

    pc_addr_unit #(.AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .reset_pc     (reset_pc),
        .rsel         (rsel),
        .execb        (execb),
        .tsel         (tsel),
        .addr_sel     (addr_sel),
        .load_addr    (load_addr),
        .load_ir      (load_ir),
        .w8           (w8),
        .sximm8       (sximm8),
        .reg_target   (reg_target),
        .dp_out       (dp_out),
        .pc           (pc),
        .pc_next      (pc_next),
        .mem_addr     (mem_addr),
        .instr_count  (instr_count),
        .branch_count (branch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the reference model with the current inputs, clock once, clear the strobes
    // and push the expected observation.
    task automatic tick();
        if (reset) begin
            m_pc = '0; m_da = '0; m_ic = '0; m_bc = '0;
        end else begin
            if (reset_pc)   m_pc = '0;
            else if (tsel)  m_pc = reg_target[AW-1:0];
            else if (execb) m_pc = m_pc + 9'd1 + sximm8[AW-1:0];
            else if (rsel)  m_pc = m_pc + 9'd1;
            if (load_addr)  m_da = dp_out[AW-1:0];
`ifdef PC_PERF_CNT_EN
            if (!w8) begin
                if (load_ir && m_ic != {CW{1'b1}})          m_ic = m_ic + 1'b1;
                if ((execb || tsel) && m_bc != {CW{1'b1}})  m_bc = m_bc + 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
        {reset, reset_pc, rsel, execb, tsel, load_addr, load_ir} = '0;
        sb.push_back('{pc: m_pc, ma: (addr_sel ? m_pc : m_da), pn: {7'd0, m_pc + 9'd1},
                       ic: m_ic, bc: m_bc});
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            reset = 1'b1;
            {reset_pc, rsel, execb, tsel, load_addr, load_ir} = 6'($urandom);
            sximm8 = 16'($urandom); reg_target = 16'($urandom); dp_out = 16'($urandom);
            addr_sel = i[0];
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e || pc !== 9'd0 || pc_next !== 16'd1) begin
                errors++;
                $display("FAIL reset[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_seq();
        obs_t e, o;
        addr_sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin tsel = 1'b1; reg_target = 16'h01FF; end
            else rsel = 1'b1;
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL seq[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_branch();
        obs_t e, o;
        logic [15:0] tgt [6] = '{16'd10, 16'd0, 16'd510, 16'd0, 16'd2, 16'd0};
        logic [15:0] off [6] = '{16'd0, 16'hFFFB, 16'd0, 16'd3, 16'd0, 16'hFFFB};
        for (int i = 0; i < 6; i++) begin
            if (i[0] == 1'b0) begin tsel = 1'b1; reg_target = tgt[i]; end
            else begin execb = 1'b1; sximm8 = off[i]; end
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_target();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            tsel = 1'b1;
            case (i)
                0: reg_target = 16'd20;
                1: reg_target = 16'h0123;
                default: begin reg_target = 16'hFE40; execb = 1'b1; sximm8 = 16'd1; end
            endcase
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL target[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_da();
        obs_t e, o;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin load_addr = 1'b1; dp_out = 16'hFE05; addr_sel = 1'b0; end
                1: addr_sel = 1'b0;
                2: reset_pc = 1'b1;
                default: addr_sel = 1'b1;
            endcase
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL da[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin rsel = 1'b1; load_addr = 1'b1; dp_out = 16'h00AA; addr_sel = 1'b0; end
                1: begin execb = 1'b1; sximm8 = 16'd7; addr_sel = 1'b1; end
                2: begin reset = 1'b1; execb = 1'b1; sximm8 = 16'd9; end
                3: begin rsel = 1'b1; load_addr = 1'b1; dp_out = 16'h1133; end
                default: addr_sel = 1'b0;
            endcase
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_counters();
        obs_t e, o;
        for (int i = 0; i < 30; i++) begin
            w8 = 1'b0;
            if (i == 0)       reset = 1'b1;
            else if (i <= 3)  load_ir = 1'b1;
            else if (i <= 5)  begin execb = 1'b1; sximm8 = 16'd1; end
            else if (i == 6)  begin tsel = 1'b1; reg_target = 16'd40; end
            else if (i <= 9)  begin w8 = 1'b1; load_ir = 1'b1; execb = 1'b1; end
            else              begin load_ir = 1'b1; rsel = 1'b1; tsel = i[0]; reg_target = 16'd3; end
            tick();
            e = sb.pop_front();
            o = '{pc, mem_addr, pc_next, instr_count, branch_count};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL cnt[%0d]: got %h want %h", i, o, e);
            end
        end
        w8 = 1'b0;
    endtask

    initial begin
        {reset, reset_pc, rsel, execb, tsel, addr_sel, load_addr, load_ir, w8} = '0;
        sximm8 = '0; reg_target = '0; dp_out = '0;
        m_pc = '0; m_da = '0; m_ic = '0; m_bc = '0;
        test_reset();
        test_seq();
        test_branch();
        test_target();
        test_da();
        test_back_to_back();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_addr_unit.md
# pc_addr_unit

Program-counter and data-address unit for the Simple RISC Machine. Holds the 9-bit PC and 9-bit data-address (DA) register, computes the next PC from the controller's strobes (`reset_pc`, `rsel`, `execb`, `tsel`), and drives the RAM address through the `addr_sel` mux. It sits between the controller (strobes), the instruction decoder (`sximm8`), the datapath (register target, ALU result) and the RAM (`mem_addr`). It also supplies the link value `pc_next` written to R7 by BL/BLX.

## Interface
Parameters:
- `AW`, 9: memory address width; PC and DA width.
- `CW`, 16: width of the optional performance counters.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `reset_pc` in 1: selects address 0 as the next PC.
- `rsel` in 1: PC load enable, sequential (PC+1).
- `execb` in 1: PC load enable, relative branch (PC+1+sximm8).
- `tsel` in 1: PC load enable, register target.
- `addr_sel` in 1: 1 drives PC onto `mem_addr`; 0 drives DA.
- `load_addr` in 1: loads DA from `dp_out`.
- `load_ir` in 1: instruction-fetch strobe (used by counters only).
- `w8` in 1: controller halted (used by counters only).
- `sximm8` in 16: sign-extended branch offset from the decoder.
- `reg_target` in 16: datapath A-register value (BX/BLX target).
- `dp_out` in 16: datapath C output (LDR/STR effective address).
- `pc` out AW: current PC.
- `pc_next` out 16: `{7'b0, pc+1}`, the link value for vsel=01.
- `mem_addr` out AW: RAM address.
- `instr_count` out CW: retired-fetch count (see Configuration).
- `branch_count` out CW: taken-branch count (see Configuration).

## Operation
- `load_pc = reset_pc | rsel | execb | tsel`. When `load_pc` is 0, the PC holds.
- Next-PC priority: `reset_pc` gives 0. Otherwise `tsel` gives `reg_target[AW-1:0]`. Otherwise `execb` gives `pc + 1 + sximm8[AW-1:0]`. Otherwise (`rsel`) the value is `pc + 1`.
- All PC arithmetic is mod 2^AW. 511+1 wraps to 0. Offsets wrap the same way (PC=2, sximm8=-5 gives 510).
- The controller asserts `reset_pc` and `rsel` together in its reset state. The result is PC=0.
- `tsel` and `execb` together is illegal. When it happens, `tsel` wins.
- DA: when `load_addr` is 1, DA is loaded with `dp_out[AW-1:0]`. Otherwise DA holds. DA is independent of the PC strobes and may load in the same cycle as the PC.
- `mem_addr = addr_sel ? pc : da`. This output is combinational.
- `pc_next` is combinational from the current PC. It always reflects the PC before any update in that cycle, so a BL issued in pc_update links to the instruction after the branch.

## Timing
- Reset (synchronous, `reset`=1 at the edge): PC=0, DA=0, both counters 0. After reset, `pc`=0, `mem_addr`=0 for either `addr_sel`, and `pc_next`=1.
- `reset` has priority over every strobe. Reset during a fetch or a branch discards the update.
- `reset_pc` clears the PC only. DA and the counters are kept.
- A new PC or DA value is visible on `pc`/`mem_addr` one cycle after the strobe.
- An ifetch issued in the cycle after a PC load sees the new PC. No bypass is required.
- Sequencing per instruction:
  - ifetch (`addr_sel`=1), then ir_load (`load_ir`=1), then pc_update (one of `rsel`/`execb`/`tsel`).
  - For BL/BLX the PC stays unchanged in pc_update. The strobe comes in jump_return or blx_return.

## Configuration
- `PC_PERF_CNT_EN` defined:
  - `instr_count` increments on each `load_ir` cycle.
  - `branch_count` increments on each cycle with `execb|tsel`.
  - Both counters saturate at 2^CW-1 and do not wrap.
  - Both freeze while `w8`=1 and clear on `reset`.
- `PC_PERF_CNT_EN` undefined: the counter logic is absent. Both outputs are tied to 0 and the ports remain present.

## Structure
- The shared package `srm_pkg` holds:
  - `ADDR_W`=9.
  - `PC_RESET_VEC`=9'd0.
  - `LINK_PAD_W`=7.
  - The next-PC source encoding used by the priority mux (`NPC_ZERO`, `NPC_REG`, `NPC_REL`, `NPC_SEQ`).
- The state registers use the existing `vDFF` with an enable mux in front.
- There is one natural sub-module, `sat_counter` (parameter CW; inputs `clk`, `reset`, `inc`, `hold`; output count). It is instantiated twice under `PC_PERF_CNT_EN`.

## Test plan
- Reset with `addr_sel`=0/1 and random strobes asserted: `pc`=0, `mem_addr`=0, `pc_next`=1, counters 0.
- From PC=0, four `rsel` pulses: PC goes 1,2,3,4. From PC=511, one `rsel` pulse gives PC=0.
- PC=10, `execb` with sximm8=16'hFFFB (-5): PC=6. PC=510, `execb` with sximm8=3: PC=2 (wrap).
- PC=20, `tsel` with reg_target=16'h0123: PC=9'h123. `tsel` and `execb` together with sximm8=1: the `tsel` target wins.
- `load_addr` with dp_out=16'hFE05 then `addr_sel`=0: `mem_addr`=9'h005 while PC is unchanged. `reset_pc` alone: PC=0 and DA still 5.
- With `PC_PERF_CNT_EN`: 3 `load_ir`, 2 `execb`, 1 `tsel` give instr_count=3 and branch_count=3. Further strobes with `w8`=1 leave the counts unchanged. Preloading to 16'hFFFF and pulsing once gives 16'hFFFF. Without the macro, both outputs stay 0.
